grey_step_tracker: RTL and testbench
====================================

Name: grey_step_tracker

Overview:
- Downstream consumer of the 5-bit binary-to-grey converter's grey output, for example a grey-coded position or encoder bus.
- Registers each valid grey sample and converts it back to binary.
- Classifies the move from the previous sample as a step up, step down, no change or illegal jump.
- Keeps a wrapping position count and a saturating error count for downstream control logic.

Parameters:
- WIDTH, 5, grey/binary code width.
- POS_W, 8, position counter width.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- g_in  in  WIDTH  grey code sample.
- g_valid  in  1  g_in valid this cycle.
- clr  in  1  clears the fault and re-primes tracking.
- b_out  out  WIDTH  registered binary equivalent of the last accepted sample.
- b_valid  out  1  one-cycle pulse when b_out updates.
- step_up  out  1  one-cycle pulse: binary value advanced by +1 (mod 2^WIDTH).
- step_dn  out  1  one-cycle pulse: binary value moved by -1 (mod 2^WIDTH).
- err  out  1  level; high while in FAULT.
- pos  out  POS_W  wrapping position count.
- err_cnt  out  ERR_W  saturating count of FAULT entries.

Behaviour:
- Reset (rst_n=0 at a clock edge) overrides everything, including mid-operation:
  - b_out=0, b_valid=0, step_up=0, step_dn=0, err=0, pos=0, err_cnt=0.
  - State goes to UNSYNC.
- Conversion:
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] XOR g[i], for i from WIDTH-2 down to 0.
  - Combinational, then registered.
- Latency: a sample accepted at edge N gives b_out, b_valid and step/err outputs valid after edge N+1. Exactly 1 cycle.
- Acceptance and priority:
  - A sample is accepted when g_valid=1 and clr=0.
  - clr=1 has priority: the same-cycle sample is dropped (no b_valid), and the state goes to UNSYNC.
  - pos and err_cnt are not cleared by clr.
- delta = b_new - b_out, computed modulo 2^WIDTH.
- State UNSYNC:
  - First accepted sample loads b_out and pulses b_valid.
  - No step pulses, pos unchanged.
  - Next state TRACK.
- State TRACK, on each accepted sample (b_out loads and b_valid pulses every time):
  - delta=0: no step.
  - delta=1: step_up, pos+1.
  - delta=2^WIDTH-1: step_dn, pos-1.
  - Any other delta: err=1, err_cnt+1, next state FAULT, pos unchanged.
- State FAULT:
  - b_out and b_valid continue to update.
  - step_up, step_dn and pos are frozen.
  - err stays 1.
  - Only clr (to UNSYNC, err=0) or reset exits.
- Wrap-around:
  - b 2^WIDTH-1 to 0 is a legal step_up; 0 to 2^WIDTH-1 is a legal step_dn.
  - pos wraps modulo 2^POS_W.
- err_cnt saturates at 2^ERR_W-1 and never wraps.
- Without g_valid, all outputs hold except the pulses (b_valid, step_up, step_dn), which return to 0.
- step_up and step_dn are never high in the same cycle.

Decomposition:
- Shared header grey_defs.vh holds:
  - state encodings ST_UNSYNC=2'd0, ST_TRACK=2'd1, ST_FAULT=2'd2;
  - default widths.
- One natural sub-module: grey_to_bin, a parameterised combinational converter, reusable as the inverse of the existing converter.
- FSM, delta classification and counters live in the top level.

Test Plan:
1. Reset, then g_in=00000 valid -> next cycle b_out=00000, b_valid=1, no step, state TRACK, pos=0.
2. Sequence g=00000, 00001, 00011 (b=0,1,2) -> two step_up pulses, pos=2; then g=00001 -> step_dn, pos=1.
3. Wrap: b=31 (g=10000) then b=0 (g=00000) -> step_up, pos+1; reverse order -> step_dn.
4. Illegal jump b=2 (g=00011) to b=5 (g=00111) -> err=1, err_cnt=1, pos unchanged. Further samples update b_out with no steps. clr with same-cycle g_valid -> sample dropped, err=0. Next sample primes with no step.
5. Repeat 260 faults with a clr between each -> err_cnt saturates at 255.
6. rst_n=0 for one cycle mid-stream with g_valid=1 -> all outputs 0, sample ignored. First post-reset sample primes with no step pulse.

Source files
------------

// File: rtl/grey_step_tracker_pkg.sv
// rtl/grey_step_tracker_pkg.sv - shared encodings and default widths for the grey step tracker
package grey_step_tracker_pkg;

    // Default widths: code width, position counter width, error counter width
    localparam int DEF_WIDTH = 5;
    localparam int DEF_POS_W = 8;
    localparam int DEF_ERR_W = 8;

    // Tracker states; the encodings are kept fixed so that external
    // debug logic can decode the state register directly
    localparam logic [1:0] ST_UNSYNC = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    // How a new binary value relates to the previously accepted one
    typedef enum logic [1:0] {
        MOVE_NONE    = 2'd0,
        MOVE_UP      = 2'd1,
        MOVE_DOWN    = 2'd2,
        MOVE_ILLEGAL = 2'd3
    } move_kind_e;

endpackage

// File: rtl/grey_to_bin.sv
// rtl/grey_to_bin.sv - parameterised combinational grey-to-binary converter
module grey_to_bin
    import grey_step_tracker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_grey,
    output logic [WIDTH-1:0] o_bin
);

    // Each binary bit is the XOR of all grey bits at or above its position,
    // written as a reduction of a shifted copy so there is no bit-to-bit chain
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_bin[i] = ^(i_grey >> i);
        end
    end

endmodule

// File: rtl/grey_step_tracker.sv
// rtl/grey_step_tracker.sv - grey sample tracker with step classification and counters
module grey_step_tracker
    import grey_step_tracker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int POS_W = DEF_POS_W,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g_in,
    input  logic             g_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] b_out,
    output logic             b_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             err,
    output logic [POS_W-1:0] pos,
    output logic [ERR_W-1:0] err_cnt
);

    // Registered state and outputs
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_b_out;
    logic             r_b_valid;
    logic             r_step_up;
    logic             r_step_dn;
    logic             r_err;
    logic [POS_W-1:0] r_pos;
    logic [ERR_W-1:0] r_err_cnt;

    // Combinational helpers
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_delta;
    logic             w_accept;
    move_kind_e       w_move;
    logic [1:0]       w_state_nxt;
    logic             w_tracking;
    logic             w_err_sat;

    grey_to_bin #(
        .WIDTH (WIDTH)
    ) u_grey_to_bin (
        .i_grey (g_in),
        .o_bin  (w_bin)
    );

    // clr always wins over a same-cycle sample
    assign w_accept   = g_valid & ~clr;
    // Difference wraps naturally in WIDTH bits, so 31->0 reads as +1
    assign w_delta    = w_bin - r_b_out;
    assign w_tracking = w_accept && (r_state == ST_TRACK);
    assign w_err_sat  = (r_err_cnt == {ERR_W{1'b1}});

    // Classify the move from the last accepted value to the incoming one
    always_comb begin
        w_move = MOVE_ILLEGAL;
        if (w_delta == '0) begin
            w_move = MOVE_NONE;
        end else if (w_delta == WIDTH'(1)) begin
            w_move = MOVE_UP;
        end else if (w_delta == {WIDTH{1'b1}}) begin
            w_move = MOVE_DOWN;
        end
    end

    // Next-state decision: clr re-primes, samples drive UNSYNC->TRACK->FAULT
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_UNSYNC;
        end else if (g_valid) begin
            case (r_state)
                ST_UNSYNC: w_state_nxt = ST_TRACK;
                ST_TRACK:  w_state_nxt = (w_move == MOVE_ILLEGAL) ? ST_FAULT : ST_TRACK;
                ST_FAULT:  w_state_nxt = ST_FAULT;
                default:   w_state_nxt = ST_UNSYNC;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_UNSYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Binary value and its valid pulse follow every accepted sample in any state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_b_out   <= '0;
            r_b_valid <= 1'b0;
        end else begin
            r_b_valid <= w_accept;
            if (w_accept) begin
                r_b_out <= w_bin;
            end
        end
    end

    // Step pulses only come out of TRACK; they default low every cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
        end else begin
            r_step_up <= w_tracking && (w_move == MOVE_UP);
            r_step_dn <= w_tracking && (w_move == MOVE_DOWN);
        end
    end

    // Error level: set on an illegal jump from TRACK, held until clr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (clr) begin
            r_err <= 1'b0;
        end else if (w_tracking && (w_move == MOVE_ILLEGAL)) begin
            r_err <= 1'b1;
        end
    end

    // Position count wraps; it is untouched by clr and frozen outside TRACK
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos <= '0;
        end else if (w_tracking) begin
            if (w_move == MOVE_UP) begin
                r_pos <= r_pos + POS_W'(1);
            end else if (w_move == MOVE_DOWN) begin
                r_pos <= r_pos - POS_W'(1);
            end
        end
    end

    // Fault-entry count saturates rather than wrapping so it never looks healthy again
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_tracking && (w_move == MOVE_ILLEGAL) && !w_err_sat) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign b_out   = r_b_out;
    assign b_valid = r_b_valid;
    assign step_up = r_step_up;
    assign step_dn = r_step_dn;
    assign err     = r_err;
    assign pos     = r_pos;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_grey_step_tracker.sv
// tb/tb_grey_step_tracker.sv - self-checking bench for grey_step_tracker
module tb_grey_step_tracker;

    localparam int W  = 5;
    localparam int PW = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  g_in;
    logic          g_valid;
    logic          clr;
    logic [W-1:0]  b_out;
    logic          b_valid;
    logic          step_up;
    logic          step_dn;
    logic          err;
    logic [PW-1:0] pos;
    logic [EW-1:0] err_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_on = 0;

    // Reference state kept as plain integers
    int  m_b, m_pos, m_errcnt;
    bit  m_bv, m_up, m_dn, m_err;
    bit  m_primed, m_fault;

    grey_step_tracker #(.WIDTH(W), .POS_W(PW), .ERR_W(EW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g_in    (g_in),
        .g_valid (g_valid),
        .clr     (clr),
        .b_out   (b_out),
        .b_valid (b_valid),
        .step_up (step_up),
        .step_dn (step_dn),
        .err     (err),
        .pos     (pos),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int to_grey(int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    function automatic int from_grey(int g);
        int b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b & 31;
    endfunction

    // Reference: one update per rising edge from the rules of the tracker
    always @(posedge clk) begin
        int bn, d;
        if (!rst_n) begin
            m_b = 0; m_bv = 0; m_up = 0; m_dn = 0; m_err = 0;
            m_pos = 0; m_errcnt = 0; m_primed = 0; m_fault = 0;
            cmp_on = 1;
        end else begin
            m_bv = 0; m_up = 0; m_dn = 0;
            if (clr) begin
                m_primed = 0; m_fault = 0; m_err = 0;
            end else if (g_valid) begin
                bn = from_grey(int'(g_in));
                m_bv = 1;
                if (!m_primed) begin
                    m_primed = 1;
                end else if (!m_fault) begin
                    d = (bn - m_b + 32) % 32;
                    if (d == 1) begin
                        m_up = 1; m_pos = (m_pos + 1) % 256;
                    end else if (d == 31) begin
                        m_dn = 1; m_pos = (m_pos + 255) % 256;
                    end else if (d != 0) begin
                        m_fault = 1; m_err = 1;
                        if (m_errcnt < 255) m_errcnt = m_errcnt + 1;
                    end
                end
                m_b = bn;
            end
        end
    end

    // Every-cycle compare against the reference, away from the clock edge
    always @(negedge clk) begin
        if (cmp_on) begin
            n_vec++;
            if (int'(b_out) != m_b || b_valid != m_bv || step_up != m_up ||
                step_dn != m_dn || err != m_err || int'(pos) != m_pos ||
                int'(err_cnt) != m_errcnt || (step_up && step_dn)) begin
                n_miss++;
                $display("FAIL cycle t=%0t got b=%0d bv=%0b up=%0b dn=%0b err=%0b pos=%0d ec=%0d want b=%0d bv=%0b up=%0b dn=%0b err=%0b pos=%0d ec=%0d",
                         $time, b_out, b_valid, step_up, step_dn, err, pos, err_cnt,
                         m_b, m_bv, m_up, m_dn, m_err, m_pos, m_errcnt);
            end
        end
    end

    task automatic check(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), return at the next falling edge
    task automatic cyc(int b, bit v, bit c, bit r);
        g_in    = W'(to_grey(b));
        g_valid = v;
        clr     = c;
        rst_n   = r;
        @(negedge clk);
    endtask

    task automatic smp(int b);
        cyc(b, 1, 0, 1);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 1);
    endtask

    initial begin
        g_in = '0; g_valid = 0; clr = 0; rst_n = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0);
        check("reset_b_out", int'(b_out), 0);
        check("reset_pos", int'(pos), 0);
        check("reset_err", int'(err), 0);

        // 1: priming sample
        smp(0);
        check("prime_bvalid", int'(b_valid), 1);
        check("prime_no_step", int'(step_up | step_dn), 0);
        check("prime_pos", int'(pos), 0);

        // 2: 0,1,2 up then back to 1
        smp(1);
        check("up1_pulse", int'(step_up), 1);
        smp(2);
        check("up2_pos", int'(pos), 2);
        smp(1);
        check("dn_pulse", int'(step_dn), 1);
        check("dn_pos", int'(pos), 1);
        idle();
        check("idle_bvalid", int'(b_valid), 0);
        check("idle_hold_b", int'(b_out), 1);

        // 3: wrap in both directions
        smp(0); smp(31);
        check("wrap_dn", int'(step_dn), 1);
        smp(0);
        check("wrap_up", int'(step_up), 1);
        smp(0);
        check("same_no_step", int'(step_up | step_dn), 0);

        // 4: illegal jump, frozen fault, clr drops sample, re-prime
        smp(1); smp(2); smp(5);
        check("fault_err", int'(err), 1);
        check("fault_errcnt", int'(err_cnt), 1);
        check("fault_pos", int'(pos), 2);
        smp(6);
        check("fault_b_moves", int'(b_out), 6);
        check("fault_no_step", int'(step_up), 0);
        cyc(7, 1, 1, 1);
        check("clr_drop_bv", int'(b_valid), 0);
        check("clr_err", int'(err), 0);
        check("clr_hold_b", int'(b_out), 6);
        smp(7);
        check("reprime_no_step", int'(step_up), 0);
        smp(8);
        check("after_reprime_up", int'(step_up), 1);

        // 5: many faults, counter saturates
        for (int k = 0; k < 260; k++) begin
            cyc(0, 0, 1, 1);
            smp(0);
            smp(5);
        end
        check("errcnt_sat", int'(err_cnt), 255);
        cyc(0, 0, 1, 1);

        // 6: mid-stream reset with a valid sample present
        smp(10); smp(11);
        cyc(12, 1, 0, 0);
        check("rst_b_out", int'(b_out), 0);
        check("rst_bvalid", int'(b_valid), 0);
        check("rst_errcnt", int'(err_cnt), 0);
        check("rst_pos", int'(pos), 0);
        smp(13);
        check("post_rst_prime_b", int'(b_out), 13);
        check("post_rst_no_step", int'(step_up | step_dn), 0);
        smp(14);
        check("post_rst_up", int'(step_up), 1);
        idle(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
